// File: rtl/maze_pkg.sv
// Shared definitions for the maze game: FSM state encoding, move direction
// indices and default map dimensions (also used by the renderer and the ROM).
package maze_pkg;

  localparam int MAP_W_DEF = 30;
  localparam int MAP_H_DEF = 21;

  // Bit positions inside the 4-bit move pulse vector.
  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  // Game FSM encoding; this value is also exported on game_state for debug.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHOW_MAP = 3'd1,
    ST_PLAY     = 3'd2,
    ST_WAIT     = 3'd3,
    ST_CHECK    = 3'd4,
    ST_WON      = 3'd5,
    ST_LOST     = 3'd6
  } game_state_e;

endpackage

// File: rtl/maze_move_decode.sv
// Combinational move decoder: picks one direction out of the move pulses by
// fixed priority (up > down > left > right), computes the target tile and
// flags whether that tile lies on the map. in_bounds is only asserted when a
// direction was actually selected, so it doubles as "move worth checking".
module maze_move_decode
  import maze_pkg::*;
#(
  parameter int MAP_W = MAP_W_DEF,
  parameter int MAP_H = MAP_H_DEF,
  parameter int XW    = $clog2(MAP_W),
  parameter int YW    = $clog2(MAP_H)
) (
  input  logic [3:0]    move,
  input  logic [XW-1:0] cur_x,
  input  logic [YW-1:0] cur_y,
  output logic [XW-1:0] target_x,
  output logic [YW-1:0] target_y,
  output logic          in_bounds
);

  // Priority select, one-tile step and edge-of-map check.
  always_comb begin
    target_x  = cur_x;
    target_y  = cur_y;
    in_bounds = 1'b0;
    if (move[DIR_UP]) begin
      target_y  = cur_y - 1'b1;
      in_bounds = (cur_y != '0);
    end else if (move[DIR_DOWN]) begin
      target_y  = cur_y + 1'b1;
      in_bounds = (cur_y != YW'(MAP_H - 1));
    end else if (move[DIR_LEFT]) begin
      target_x  = cur_x - 1'b1;
      in_bounds = (cur_x != '0);
    end else if (move[DIR_RIGHT]) begin
      target_x  = cur_x + 1'b1;
      in_bounds = (cur_x != XW'(MAP_W - 1));
    end
  end

endmodule

// File: rtl/maze_player_engine.sv
// Game-play core: game FSM, player position, timed map reveal, collision
// lookup against a synchronous map ROM, strike and move counters.
// Input protocol: start and move are single-cycle pulses with no ready/back-
// pressure; a pulse that arrives while the engine cannot act on it is dropped.
module maze_player_engine
  import maze_pkg::*;
#(
  parameter int  MAP_W       = MAP_W_DEF,
  parameter int  MAP_H       = MAP_H_DEF,
  parameter int  START_X     = 0,
  parameter int  START_Y     = 11,
  parameter int  GOAL_X      = 29,
  parameter int  GOAL_Y      = 9,
  parameter int  SHOW_CYCLES = 1000000,
  parameter int  MAX_STRIKES = 3,
  localparam int XW          = $clog2(MAP_W),
  localparam int YW          = $clog2(MAP_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       move,
  output logic [YW-1:0]    rom_addr,
  input  logic [MAP_W-1:0] rom_data,
  output logic [XW-1:0]    player_x,
  output logic [YW-1:0]    player_y,
  output logic             map_visible,
  output logic             won,
  output logic             lost,
  output logic [3:0]       strikes,
  output logic [15:0]      move_count,
  output logic [2:0]       game_state
);

  localparam int TW = $clog2(SHOW_CYCLES + 1);

  game_state_e   state_q, state_d;
  logic [TW-1:0] timer_q;
  logic [XW-1:0] tgt_x_q;
  logic [YW-1:0] tgt_y_q;
  logic [XW-1:0] dec_x;
  logic [YW-1:0] dec_y;
  logic          dec_ok;
  logic          timer_last;
  logic          wall;
  logic          at_goal;
  logic          strikes_last;
  logic          do_init;
  logic          do_launch;
  logic          do_check;
  logic [MAP_W-1:0] row_shifted;

  maze_move_decode #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H),
    .XW    (XW),
    .YW    (YW)
  ) u_decode (
    .move      (move),
    .cur_x     (player_x),
    .cur_y     (player_y),
    .target_x  (dec_x),
    .target_y  (dec_y),
    .in_bounds (dec_ok)
  );

  // Column 0 is the row MSB, so shifting left by the column brings the
  // addressed tile into the MSB.
  assign row_shifted  = rom_data << tgt_x_q;
  assign wall         = row_shifted[MAP_W-1];
  assign at_goal      = (tgt_x_q == XW'(GOAL_X)) && (tgt_y_q == YW'(GOAL_Y));
  assign strikes_last = ((strikes + 4'd1) == 4'(MAX_STRIKES));
  assign timer_last   = (timer_q == TW'(SHOW_CYCLES - 1));
  assign game_state   = state_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and datapath strobes; start overrides everything.
  always_comb begin
    state_d   = state_q;
    do_init   = 1'b0;
    do_launch = 1'b0;
    do_check  = 1'b0;
    if (start) begin
      state_d = ST_SHOW_MAP;
      do_init = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_IDLE;
        ST_SHOW_MAP: if (timer_last) state_d = ST_PLAY;
        ST_PLAY: begin
          if (dec_ok) begin
            state_d   = ST_WAIT;
            do_launch = 1'b1;
          end
        end
        ST_WAIT:     state_d = ST_CHECK;
        ST_CHECK: begin
          do_check = 1'b1;
          if (wall) state_d = strikes_last ? ST_LOST : ST_PLAY;
          else      state_d = at_goal ? ST_WON : ST_PLAY;
        end
        ST_WON:      state_d = ST_WON;
        ST_LOST:     state_d = ST_LOST;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Reveal timer: counts only while the map is being shown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     timer_q <= '0;
    else if (do_init)               timer_q <= '0;
    else if (state_q == ST_SHOW_MAP) timer_q <= timer_last ? '0 : timer_q + 1'b1;
  end

  // Target latch and ROM row address for an accepted move.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tgt_x_q  <= '0;
      tgt_y_q  <= '0;
      rom_addr <= '0;
    end else if (do_launch) begin
      tgt_x_q  <= dec_x;
      tgt_y_q  <= dec_y;
      rom_addr <= dec_y;
    end
  end

  // Player position, strikes and move counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      player_x   <= XW'(START_X);
      player_y   <= YW'(START_Y);
      strikes    <= '0;
      move_count <= '0;
    end else if (do_init) begin
      player_x   <= XW'(START_X);
      player_y   <= YW'(START_Y);
      strikes    <= '0;
      move_count <= '0;
    end else if (do_check) begin
      if (wall) begin
        strikes <= strikes + 4'd1;
      end else begin
        player_x <= tgt_x_q;
        player_y <= tgt_y_q;
        if (move_count != 16'hFFFF) move_count <= move_count + 16'd1;
      end
    end
  end

  // Registered status flags, derived from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      map_visible <= 1'b0;
      won         <= 1'b0;
      lost        <= 1'b0;
    end else begin
      map_visible <= (state_d == ST_SHOW_MAP) || (state_d == ST_WON) ||
                     (state_d == ST_LOST);
      won         <= (state_d == ST_WON);
      lost        <= (state_d == ST_LOST);
    end
  end

endmodule

// File: tb/tb_maze_player_engine.sv
// Bench for maze_player_engine: synchronous map ROM model, directed scenarios
// and random move streams compared against a tile-level game model.
module tb_maze_player_engine;

  localparam int MAP_W = 30;
  localparam int MAP_H = 21;
  localparam int SHOW  = 8;
  localparam int MAXS  = 3;
  localparam int XW    = 5;
  localparam int YW    = 5;
  localparam int SX    = 0;
  localparam int SY    = 11;
  localparam int GX    = 29;
  localparam int GY    = 9;

  localparam int S_IDLE  = 0;
  localparam int S_SHOW  = 1;
  localparam int S_PLAY  = 2;
  localparam int S_WAIT  = 3;
  localparam int S_WON   = 5;
  localparam int S_LOST  = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       move = 4'd0;
  logic [YW-1:0]    rom_addr;
  logic [MAP_W-1:0] rom_data = '0;
  logic [XW-1:0]    player_x;
  logic [YW-1:0]    player_y;
  logic             map_visible;
  logic             won;
  logic             lost;
  logic [3:0]       strikes;
  logic [15:0]      move_count;
  logic [2:0]       game_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: {won, lost, strikes[3:0], count[15:0], y[4:0], x[4:0]}.
  logic [31:0] exp_q[$];

  // Map: rom_mem[y] bit (MAP_W-1-x) is 1 for a wall.
  logic [MAP_W-1:0] rom_mem[MAP_H];

  // Game model state.
  int mx, my, mstr, mcnt;
  bit mwon, mlost;

  maze_player_engine #(
    .MAP_W       (MAP_W),
    .MAP_H       (MAP_H),
    .START_X     (SX),
    .START_Y     (SY),
    .GOAL_X      (GX),
    .GOAL_Y      (GY),
    .SHOW_CYCLES (SHOW),
    .MAX_STRIKES (MAXS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .move        (move),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .player_x    (player_x),
    .player_y    (player_y),
    .map_visible (map_visible),
    .won         (won),
    .lost        (lost),
    .strikes     (strikes),
    .move_count  (move_count),
    .game_state  (game_state)
  );

  // Clock and synchronous ROM with one cycle of read latency.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (int'(rom_addr) < MAP_H) rom_data <= rom_mem[rom_addr];
    else                        rom_data <= '0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_wall(input int x, input int y);
    logic [MAP_W-1:0] row;
    row = rom_mem[y];
    return row[MAP_W-1-x];
  endfunction

  function automatic void set_tile(input int x, input int y, input bit w);
    rom_mem[y][MAP_W-1-x] = w;
  endfunction

  // Random walls, with a guaranteed corridor from spawn to goal
  // ((0,11)->(1,11)->(1,10)->(1,9)->row 9 to (29,9)) and a wall at (2,11).
  task automatic build_map(input int density);
    for (int y = 0; y < MAP_H; y++)
      for (int x = 0; x < MAP_W; x++)
        set_tile(x, y, ($urandom_range(0, 99) < density));
    set_tile(0, 11, 1'b0);
    set_tile(1, 11, 1'b0);
    set_tile(1, 10, 1'b0);
    for (int x = 1; x < MAP_W; x++) set_tile(x, 9, 1'b0);
    set_tile(2, 11, 1'b1);
  endtask

  function automatic void model_reset();
    mx = SX; my = SY; mstr = 0; mcnt = 0; mwon = 1'b0; mlost = 1'b0;
  endfunction

  // One move pulse at tile level: acc says whether the ROM gets consulted.
  function automatic void model_move(input logic [3:0] m, output bit acc, output int ny_o);
    int dx, dy, nx, ny;
    dx = 0; dy = 0; acc = 1'b0; ny_o = 0;
    if (mwon || mlost) return;
    if (m[0])      dy = -1;
    else if (m[1]) dy = 1;
    else if (m[2]) dx = -1;
    else if (m[3]) dx = 1;
    else return;
    nx = mx + dx;
    ny = my + dy;
    if (nx < 0 || nx >= MAP_W || ny < 0 || ny >= MAP_H) return;
    acc = 1'b1;
    ny_o = ny;
    if (is_wall(nx, ny)) begin
      mstr++;
      if (mstr == MAXS) mlost = 1'b1;
    end else begin
      mx = nx;
      my = ny;
      if (mcnt < 65535) mcnt++;
      if (nx == GX && ny == GY) mwon = 1'b1;
    end
  endfunction

  // Pulse one move and compare the settled result three cycles later.
  // With drop_follow, a second pulse is injected during WAIT and must vanish.
  task automatic do_move(input logic [3:0] m, input bit drop_follow);
    bit acc;
    int ny, ox, oy;
    logic [31:0] e;
    ox = mx;
    oy = my;
    model_move(m, acc, ny);
    exp_q.push_back({mwon, mlost, 4'(mstr), 16'(mcnt), 5'(my), 5'(mx)});
    move = m;
    tick();
    move = (drop_follow && acc) ? 4'($urandom_range(1, 15)) : 4'd0;
    if (acc) begin
      check("wait_state", 32'(game_state), S_WAIT);
      check("wait_rom_addr", 32'(rom_addr), ny);
    end
    tick();
    move = 4'd0;
    check("pre_update_x", 32'(player_x), ox);
    check("pre_update_y", 32'(player_y), oy);
    tick();
    e = exp_q.pop_front();
    check("pos_x", 32'(player_x), 32'(e[4:0]));
    check("pos_y", 32'(player_y), 32'(e[9:5]));
    check("move_count", 32'(move_count), 32'(e[25:10]));
    check("strikes", 32'(strikes), 32'(e[29:26]));
    check("lost", 32'(lost), 32'(e[30]));
    check("won", 32'(won), 32'(e[31]));
    check("visible", 32'(map_visible), 32'(e[31] | e[30]));
    check("state", 32'(game_state), e[31] ? S_WON : (e[30] ? S_LOST : S_PLAY));
  endtask

  // Start pulse, then count the reveal window until play begins.
  task automatic start_game(input bit poke_move);
    int vis;
    start = 1'b1;
    tick();
    start = 1'b0;
    model_reset();
    check("start_state", 32'(game_state), S_SHOW);
    check("start_won", 32'(won), 0);
    check("start_lost", 32'(lost), 0);
    check("start_x", 32'(player_x), SX);
    check("start_y", 32'(player_y), SY);
    vis = 0;
    for (int i = 0; i < 20; i++) begin
      if (!map_visible) break;
      vis++;
      if (poke_move && i == 2) move = 4'b1000;
      tick();
      move = 4'd0;
    end
    check("show_cycles", vis, SHOW);
    check("play_state", 32'(game_state), S_PLAY);
    check("play_x", 32'(player_x), SX);
    check("play_y", 32'(player_y), SY);
    check("play_strikes", 32'(strikes), 0);
    check("play_count", 32'(move_count), 0);
  endtask

  initial begin
    build_map(30);

    // Reset values.
    #23;
    check("rst_state", 32'(game_state), S_IDLE);
    check("rst_x", 32'(player_x), SX);
    check("rst_y", 32'(player_y), SY);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_strikes", 32'(strikes), 0);
    check("rst_count", 32'(move_count), 0);
    check("rst_visible", 32'(map_visible), 0);
    check("rst_won", 32'(won), 0);
    check("rst_lost", 32'(lost), 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // IDLE ignores moves.
    move = 4'b1000;
    tick();
    move = 4'd0;
    repeat (3) tick();
    check("idle_state", 32'(game_state), S_IDLE);
    check("idle_x", 32'(player_x), SX);

    // First game: reveal window (move during reveal is ignored).
    start_game(1'b1);

    // Left at column 0: off-map, no ROM access.
    do_move(4'b0100, 1'b0);
    check("offmap_rom_addr", 32'(rom_addr), 0);
    do_move(4'b1000, 1'b0);          // right to (1,11)
    do_move(4'b1001, 1'b0);          // up+right: up wins -> (1,10)
    check("prio_y", 32'(player_y), 10);
    do_move(4'b0010, 1'b0);          // back down to (1,11)
    for (int k = 0; k < 3; k++) do_move(4'b1000, 1'b0);  // wall at (2,11)
    check("lost_flag", 32'(lost), 1);
    do_move(4'b0100, 1'b0);          // ignored after loss

    // Restart, then abort a pending move with another start.
    start_game(1'b0);
    move = 4'b1000;
    tick();
    move = 4'd0;
    start_game(1'b0);

    // Walk the corridor to the goal; a pulse during WAIT is dropped.
    do_move(4'b1000, 1'b1);
    do_move(4'b0001, 1'b0);
    do_move(4'b0001, 1'b0);
    for (int k = 0; k < 28; k++) do_move(4'b1000, 1'b0);
    check("won_flag", 32'(won), 1);
    check("won_moves", 32'(move_count), 31);
    do_move(4'b0100, 1'b0);          // frozen after win

    // Random games against the model.
    for (int g = 0; g < 3; g++) begin
      build_map(25);
      start_game(1'b0);
      for (int k = 0; k < 50; k++) begin
        do_move(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        repeat ($urandom_range(0, 2)) tick();
      end
    end

    // Asynchronous reset in the middle of a pending move.
    build_map(25);
    start_game(1'b0);
    do_move(4'b1000, 1'b0);          // now at (1,11)
    move = 4'b0001;                  // up to open (1,10)
    tick();
    move = 4'd0;
    check("arst_pre_state", 32'(game_state), S_WAIT);
    #2;
    reset = 1'b0;
    #1;
    check("arst_state", 32'(game_state), S_IDLE);
    check("arst_x", 32'(player_x), SX);
    check("arst_y", 32'(player_y), SY);
    check("arst_rom_addr", 32'(rom_addr), 0);
    check("arst_count", 32'(move_count), 0);
    check("arst_visible", 32'(map_visible), 0);
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) tick();
    check("arst_after_state", 32'(game_state), S_IDLE);
    check("arst_after_y", 32'(player_y), SY);
    check("arst_after_count", 32'(move_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
